// File: rtl/remapper_stream.sv
// -----------------------------------------------------------------------------
// remapper_stream
//
// Purpose
//   Accepts one image kernel of DIM_I*DIM_J*DIM_K pixels per valid/ready
//   handshake. Each kernel is reordered according to the mode sampled with
//   it: pass-through, forward tile remap, or reversed tile remap. Results go
//   through a 2-entry output buffer. Upstream ready is decoded purely from
//   buffer occupancy, so there is no combinational path from the downstream
//   ready to the upstream ready.
//
// Ports
//   i_clk           : clock, rising edge
//   i_aresetn       : asynchronous active-low reset
//   i_image_kernel  : source kernel, element 0 first (leftmost)
//   i_kernel_valid  : source kernel valid
//   i_mode          : 00 pass, 01 forward, 10 reversed, 11 reserved (passes)
//   o_kernel_ready  : a kernel can be accepted this cycle
//   o_image_kernel  : remapped kernel at the head of the buffer
//   o_kernel_valid  : remapped kernel valid
//   i_kernel_ready  : downstream accepts the remapped kernel
//   i_count_clear   : synchronous clear of o_kernel_count and o_mode_err
//   o_kernel_count  : kernels delivered downstream (wraps)
//   o_mode_err      : sticky flag, a kernel was accepted with mode 11
// -----------------------------------------------------------------------------
module remapper_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIM_I       = 4,
  parameter int DIM_J       = 8,
  parameter int DIM_K       = 2,
  parameter int COUNT_WIDTH = 16,
  localparam int KERNEL     = DIM_I * DIM_J * DIM_K
) (
  input  logic                                i_clk,
  input  logic                                i_aresetn,
  input  logic [0:KERNEL-1][DATA_WIDTH-1:0]   i_image_kernel,
  input  logic                                i_kernel_valid,
  input  logic [1:0]                          i_mode,
  output logic                                o_kernel_ready,
  output logic [0:KERNEL-1][DATA_WIDTH-1:0]   o_image_kernel,
  output logic                                o_kernel_valid,
  input  logic                                i_kernel_ready,
  input  logic                                i_count_clear,
  output logic [COUNT_WIDTH-1:0]              o_kernel_count,
  output logic                                o_mode_err
);

  typedef logic [0:KERNEL-1][DATA_WIDTH-1:0] kernel_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Remap network. Pure wiring: every source element lands at exactly one
  // destination in each of the forward and reversed orderings.
  // ---------------------------------------------------------------------------
  kernel_t fwd_kernel;
  kernel_t rev_kernel;
  kernel_t remap_kernel;

  for (genvar gk = 0; gk < DIM_K; gk++) begin : g_k
    for (genvar gj = 0; gj < DIM_J; gj++) begin : g_j
      for (genvar gi = 0; gi < DIM_I; gi++) begin : g_i
        localparam int SRC = gk * DIM_I * DIM_J + gj * DIM_I + gi;
        localparam int FWD = gi * DIM_J * DIM_K + gj * DIM_K + gk;
        assign fwd_kernel[FWD]          = i_image_kernel[SRC];
        assign rev_kernel[KERNEL-1-FWD] = i_image_kernel[SRC];
      end
    end
  end

  always_comb begin
    remap_kernel = i_image_kernel;
    case (mode_e'(i_mode))
      MODE_FWD: remap_kernel = fwd_kernel;
      MODE_REV: remap_kernel = rev_kernel;
      default:  remap_kernel = i_image_kernel;  // pass and reserved
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer
  // ---------------------------------------------------------------------------
  kernel_t                buf_q [2];
  kernel_t                buf_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             occ_q, occ_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   mode_err_q, mode_err_d;

  logic push;
  logic pop;

  // Ready depends on registered occupancy only; a pop in the same cycle
  // does not open a slot for a push when the buffer is full.
  assign o_kernel_ready = (occ_q != 2'd2);
  assign o_kernel_valid = (occ_q != 2'd0);
  assign o_image_kernel = buf_q[rd_ptr_q];
  assign o_kernel_count = count_q;
  assign o_mode_err     = mode_err_q;

  assign push = i_kernel_valid & o_kernel_ready;
  assign pop  = o_kernel_valid & i_kernel_ready;

  always_comb begin
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    count_d    = count_q;
    mode_err_d = mode_err_q;

    if (push) begin
      buf_d[wr_ptr_q] = remap_kernel;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;  // idle, or push+pop at occupancy 1
    endcase

    // Clear wins over a same-cycle transfer or reserved-mode accept.
    if (i_count_clear) begin
      count_d    = '0;
      mode_err_d = 1'b0;
    end else begin
      if (pop) begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
      if (push && (mode_e'(i_mode) == MODE_RSVD)) begin
        mode_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      count_q    <= '0;
      mode_err_q <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      mode_err_q <= mode_err_d;
    end
  end

endmodule

// File: tb/tb_remapper_stream.sv
module tb_remapper_stream;

  localparam int K  = 64;   // default kernel size (4*8*2)
  localparam int KS = 12;   // alternate kernel size (2*3*2)

  typedef logic [0:K-1][7:0]  kernel_t;
  typedef logic [0:KS-1][7:0] kernel_s_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default-parameter instance
  kernel_t     in_kernel;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic        clear;
  logic        dut_ready;
  kernel_t     dut_kernel;
  logic        dut_valid;
  logic [15:0] dut_count;
  logic        dut_err;

  // alternate-parameter instance
  kernel_s_t   s_in_kernel;
  logic        s_in_valid;
  logic [1:0]  s_mode;
  logic        s_out_ready;
  logic        s_clear;
  logic        s_ready;
  kernel_s_t   s_kernel;
  logic        s_valid;
  logic [3:0]  s_count;
  logic        s_err;

  int n_vec = 0;
  int n_bad = 0;

  remapper_stream dut (
    .i_clk          (clk),
    .i_aresetn      (rst_n),
    .i_image_kernel (in_kernel),
    .i_kernel_valid (in_valid),
    .i_mode         (in_mode),
    .o_kernel_ready (dut_ready),
    .o_image_kernel (dut_kernel),
    .o_kernel_valid (dut_valid),
    .i_kernel_ready (out_ready),
    .i_count_clear  (clear),
    .o_kernel_count (dut_count),
    .o_mode_err     (dut_err)
  );

  remapper_stream #(
    .DATA_WIDTH (8),
    .DIM_I      (2),
    .DIM_J      (3),
    .DIM_K      (2),
    .COUNT_WIDTH(4)
  ) dut_small (
    .i_clk          (clk),
    .i_aresetn      (rst_n),
    .i_image_kernel (s_in_kernel),
    .i_kernel_valid (s_in_valid),
    .i_mode         (s_mode),
    .o_kernel_ready (s_ready),
    .o_image_kernel (s_kernel),
    .o_kernel_valid (s_valid),
    .i_kernel_ready (s_out_ready),
    .i_count_clear  (s_clear),
    .o_kernel_count (s_count),
    .o_mode_err     (s_err)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic kernel_t ramp(input int base);
    kernel_t r;
    for (int n = 0; n < K; n++) r[n] = 8'(base + n);
    return r;
  endfunction

  function automatic kernel_s_t ramp_s(input int base);
    kernel_s_t r;
    for (int n = 0; n < KS; n++) r[n] = 8'(base + n);
    return r;
  endfunction

  // Reference: walk destinations, decode the forward index of each
  // destination back into (i,j,k), then fetch the matching source element.
  // Element n of an ne-element kernel sits at bits [(ne-1-n)*8 +: 8].
  function automatic logic [511:0] ref_map(input logic [511:0] src, input int di,
                                           input int dj, input int dk, input logic [1:0] mode);
    logic [511:0] r;
    int ne, f, i, j, k, s;
    r  = '0;
    ne = di * dj * dk;
    for (int d = 0; d < ne; d++) begin
      f = (mode == 2'b10) ? (ne - 1 - d) : d;
      i = f / (dj * dk);
      j = (f / dk) % dj;
      k = f % dk;
      s = (mode == 2'b01 || mode == 2'b10) ? (k * di * dj + j * di + i) : d;
      r[(ne-1-d)*8 +: 8] = src[(ne-1-s)*8 +: 8];
    end
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    in_kernel = '0; in_valid = 1'b0; in_mode = 2'b00; out_ready = 1'b0; clear = 1'b0;
    s_in_kernel = '0; s_in_valid = 1'b0; s_mode = 2'b00; s_out_ready = 1'b0; s_clear = 1'b0;

    // ---------------- reset state
    tick(); tick();
    check("rst_valid", dut_valid, 0);
    check("rst_kernel", dut_kernel, 0);
    check("rst_count", dut_count, 0);
    check("rst_err", dut_err, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", dut_ready, 1);
    tick();
    check("rel_ready", dut_ready, 1);
    check("rel_valid", dut_valid, 0);

    // ---------------- 1: forward remap
    in_kernel = ramp(0); in_mode = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid", dut_valid, 1);
    check("t1_dst0", dut_kernel[0], 0);
    check("t1_dst1", dut_kernel[1], 32);
    check("t1_dst2", dut_kernel[2], 4);
    check("t1_dst16", dut_kernel[16], 1);
    check("t1_dst63", dut_kernel[63], 63);
    check("t1_full", dut_kernel, ref_map(ramp(0), 4, 8, 2, 2'b01));
    tick();
    check("t1_count", dut_count, 1);
    check("t1_drained", dut_valid, 0);

    // ---------------- 2: reversed remap
    in_mode = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t2_dst0", dut_kernel[0], 63);
    check("t2_dst1", dut_kernel[1], 31);
    check("t2_dst62", dut_kernel[62], 32);
    check("t2_dst63", dut_kernel[63], 0);
    check("t2_full", dut_kernel, ref_map(ramp(0), 4, 8, 2, 2'b10));
    tick();
    check("t2_count", dut_count, 2);

    // ---------------- 3: backpressure with three back-to-back kernels
    out_ready = 1'b0; in_mode = 2'b00; in_valid = 1'b1;
    in_kernel = ramp(10);
    tick();
    check("t3_rdy_after1", dut_ready, 1);
    check("t3_head_a", dut_kernel, ramp(10));
    in_kernel = ramp(20);
    tick();
    check("t3_rdy_after2", dut_ready, 0);
    check("t3_hold_a", dut_kernel, ramp(10));
    in_kernel = ramp(30);
    tick();
    check("t3_rdy_stall", dut_ready, 0);
    check("t3_stable_a", dut_kernel, ramp(10));
    check("t3_valid_stall", dut_valid, 1);
    out_ready = 1'b1;
    tick();
    check("t3_head_b", dut_kernel, ramp(20));
    check("t3_rdy_open", dut_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_head_c", dut_kernel, ramp(30));
    check("t3_valid_c", dut_valid, 1);
    tick();
    check("t3_empty", dut_valid, 0);
    check("t3_count", dut_count, 5);

    // ---------------- 4: occupancy 1 with simultaneous push and pop
    out_ready = 1'b0; in_valid = 1'b1; in_kernel = ramp(100);
    tick();
    out_ready = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      in_kernel = ramp(100 + n);
      tick();
      check($sformatf("t4_head_%0d", n), dut_kernel[0], 8'(100 + n));
      check($sformatf("t4_valid_%0d", n), dut_valid, 1);
      check($sformatf("t4_ready_%0d", n), dut_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("t4_count", dut_count, 16);
    check("t4_empty", dut_valid, 0);

    // ---------------- 5: reserved mode and clear priority
    check("t5_err_before", dut_err, 0);
    out_ready = 1'b0; in_mode = 2'b11; in_kernel = ramp(7); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_pass", dut_kernel, ramp(7));
    check("t5_pass_ref", dut_kernel, ref_map(ramp(7), 4, 8, 2, 2'b11));
    check("t5_err_set", dut_err, 1);
    out_ready = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_count_clr", dut_count, 0);
    check("t5_err_clr", dut_err, 0);
    check("t5_popped", dut_valid, 0);

    // ---------------- 6a: reset with two kernels buffered
    in_mode = 2'b00; in_valid = 1'b1; in_kernel = ramp(40);
    tick();
    in_kernel = ramp(50);
    tick();
    out_ready = 1'b0; in_mode = 2'b11; in_kernel = ramp(60);
    tick();
    in_valid = 1'b0;
    check("t6_pre_count", dut_count, 1);
    check("t6_pre_ready", dut_ready, 0);
    check("t6_pre_head", dut_kernel, ramp(50));
    check("t6_pre_err", dut_err, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", dut_valid, 0);
    check("t6_rst_kernel", dut_kernel, 0);
    check("t6_rst_count", dut_count, 0);
    check("t6_rst_err", dut_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_rel_ready", dut_ready, 1);
    check("t6_rel_valid", dut_valid, 0);

    // ---------------- 6b: alternate dimensions and 4-bit count wrap
    s_in_kernel = ramp_s(0); s_mode = 2'b01; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    s_in_valid = 1'b0;
    check("s_fwd_dst1", s_kernel[1], 6);
    check("s_fwd_dst2", s_kernel[2], 2);
    check("s_fwd_dst6", s_kernel[6], 1);
    check("s_fwd_full", s_kernel, ref_map(ramp_s(0), 2, 3, 2, 2'b01));
    s_mode = 2'b10; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    check("s_rev_dst0", s_kernel[0], 11);
    check("s_rev_dst11", s_kernel[11], 0);
    check("s_rev_full", s_kernel, ref_map(ramp_s(0), 2, 3, 2, 2'b10));
    tick();
    check("s_count2", s_count, 2);
    s_in_valid = 1'b1;
    for (int n = 0; n < 15; n++) tick();
    s_in_valid = 1'b0;
    tick();
    check("s_count_wrap", s_count, 1);
    check("s_empty", s_valid, 0);
    check("s_err", s_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
